// File: rtl/load_store_unit_pkg.sv
// Shared constants, FSM encoding and legality helper for the load/store unit.
package load_store_unit_pkg;

  localparam int LSU_ADDR_WIDTH = 10;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} lsu_state_e;

  // Illegal opcode or misaligned access; funct3[1:0] encodes the access size.
  function automatic logic op_illegal(input logic write, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (write) bad = (f3 > F3_SW);
    else       bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    if (f3[1:0] == 2'd1 && off[0])       bad = 1'b1;
    if (f3[1:0] == 2'd2 && off != 2'b00) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/halfword lane extraction with sign/zero extension, and store lane merge.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word_i[{off_i, 3'b000} +: 8];
    h = off_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_LB:   load_o = {{24{b[7]}}, b};
      F3_LH:   load_o = {{16{h[15]}}, h};
      F3_LW:   load_o = word_i;
      F3_LBU:  load_o = {24'd0, b};
      F3_LHU:  load_o = {16'd0, h};
      default: load_o = '0;
    endcase

    // Sub-word stores overwrite one lane of the word read back from RAM.
    store_o = word_i;
    case (funct3_i)
      F3_SB: store_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_SH: begin
        if (off_i[1]) store_o[31:16] = wdata_i[15:0];
        else          store_o[15:0]  = wdata_i[15:0];
      end
      default: store_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit in front of a word-addressed RAM
// with combinational read data; sub-word stores are read-modify-write.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_fault,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_e            state_q, state_d;
  logic                  write_q, fault_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q, rdata_q;
  logic [31:0]           ld_word, st_word;
  logic                  accept, req_fault;

  assign accept    = req_valid && (state_q == S_IDLE);
  assign req_fault = (|req_addr[31:ADDR_WIDTH+2]) ||
                     op_illegal(req_write, req_funct3, req_addr[1:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_fault)                               state_d = S_RESP;
          else if (req_write && req_funct3 == F3_SW)   state_d = S_WRITE;
          else                                         state_d = S_READ;
        end
      end
      S_READ:  state_d = write_q ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      fault_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= req_write;
        fault_q  <= req_fault;
        funct3_q <= req_funct3;
        addr_q   <= req_addr[ADDR_WIDTH+1:0];
        wdata_q  <= req_wdata;
      end
      if (state_q == S_READ) rdata_q <= mem_rdata;
    end
  end

  lsu_align u_align (
    .funct3_i (funct3_q),
    .off_i    (addr_q[1:0]),
    .word_i   (rdata_q),
    .wdata_i  (wdata_q),
    .load_o   (ld_word),
    .store_o  (st_word)
  );

  // All outputs derive from registered state, so they hold steady within a cycle.
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_fault = resp_valid && fault_q;
  assign resp_rdata = (resp_valid && !fault_q && !write_q) ? ld_word : '0;
  assign mem_we     = (state_q == S_WRITE);
  assign mem_addr   = addr_q[ADDR_WIDTH+1:2];
  assign mem_wdata  = mem_we ? st_word : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a byte-level memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM with combinational read, plus write/acceptance monitors
  logic [31:0] ram [0:1023];
  int          we_cnt = 0;
  int          acc_cnt = 0;
  logic [9:0]  we_addr = '0;
  logic [31:0] we_data = '0;

  assign mem_rdata = ram[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      we_cnt  <= we_cnt + 1;
      we_addr <= mem_addr;
      we_data <= mem_wdata;
    end
    if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model: byte-addressed memory, results from the ISA rules
  logic [7:0] rb [0:4095];

  task automatic ref_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] erd,
                        output logic eflt, output int elat, output int ewes);
    int     sz;
    longint v;
    sz   = 1 << (f3 % 4);
    eflt = (a >= 4096) || (a % sz != 0) || (w ? (f3 > 2) : (f3 == 3 || f3 >= 6));
    erd  = '0;
    if (eflt) begin
      elat = 1; ewes = 0;
    end else if (w) begin
      for (int i = 0; i < sz; i++) rb[a + i] = wd[8*i +: 8];
      elat = (sz == 4) ? 2 : 3;
      ewes = 1;
    end else begin
      v = 0;
      for (int i = sz - 1; i >= 0; i--) v = v * 256 + longint'(rb[a + i]);
      if (f3 < 4 && v >= (longint'(1) << (8*sz - 1))) v = v - (longint'(1) << (8*sz));
      erd  = v[31:0];
      elat = 2; ewes = 0;
    end
  endtask

  task automatic lsu_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic flt, output int lat, output int wes);
    int we0;
    we0 = we_cnt;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    lat = 1;
    while (!resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    rd  = resp_rdata;
    flt = resp_fault;
    @(posedge clk); #1;
    wes = we_cnt - we0;
    check("resp_valid_after_xfer", {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic run(input string tag, input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    logic [31:0] erd;
    logic        eflt, flt;
    int          elat, ewes, lat, wes, wa;
    ref_op(w, f3, a, wd, erd, eflt, elat, ewes);
    lsu_op(w, f3, a, wd, rd, flt, lat, wes);
    check({tag, "_rdata"}, rd, erd);
    check({tag, "_fault"}, {31'd0, flt}, {31'd0, eflt});
    check({tag, "_latency"}, lat, elat);
    check({tag, "_we_cycles"}, wes, ewes);
    if (w && !eflt) begin
      wa = int'(a) & ~3;
      check({tag, "_ram"}, ram[a[11:2]], {rb[wa+3], rb[wa+2], rb[wa+1], rb[wa]});
    end
  endtask

  logic [31:0] rd;
  int          acc0;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",  {31'd0, req_ready},  32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_we",     {31'd0, mem_we},     32'd0);
    check("rst_mem_addr",   {22'd0, mem_addr},   32'd0);
    check("rst_mem_wdata",  mem_wdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Word store then load back
    run("sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd);
    check("sw10_we_addr", {22'd0, we_addr}, 32'd4);
    check("sw10_we_data", we_data, 32'hDEADBEEF);
    run("lw10", 1'b0, 3'd2, 32'h10, 32'h0, rd);
    check("lw10_const", rd, 32'hDEADBEEF);

    // Sub-word loads with sign and zero extension
    run("sw10b", 1'b1, 3'd2, 32'h10, 32'h8000FF7F, rd);
    run("lb10",  1'b0, 3'd0, 32'h10, 32'h0, rd); check("lb10_const",  rd, 32'h0000007F);
    run("lb11",  1'b0, 3'd0, 32'h11, 32'h0, rd); check("lb11_const",  rd, 32'hFFFFFFFF);
    run("lbu11", 1'b0, 3'd4, 32'h11, 32'h0, rd); check("lbu11_const", rd, 32'h000000FF);
    run("lh12",  1'b0, 3'd1, 32'h12, 32'h0, rd); check("lh12_const",  rd, 32'hFFFF8000);
    run("lhu12", 1'b0, 3'd5, 32'h12, 32'h0, rd); check("lhu12_const", rd, 32'h00008000);

    // Read-modify-write stores
    run("sw20", 1'b1, 3'd2, 32'h20, 32'h11223344, rd);
    run("sb21", 1'b1, 3'd0, 32'h21, 32'h000000AA, rd);
    check("sb21_word", ram[8], 32'h1122AA44);
    run("sh22", 1'b1, 3'd1, 32'h22, 32'h0000BEEF, rd);
    check("sh22_word", ram[8], 32'hBEEFAA44);

    // Faults
    run("lw13_fault",   1'b0, 3'd2, 32'h13,   32'h0, rd);
    run("sh01_fault",   1'b1, 3'd1, 32'h01,   32'h1234, rd);
    run("lw1000_fault", 1'b0, 3'd2, 32'h1000, 32'h0, rd);
    run("ld_f3_3",      1'b0, 3'd3, 32'h10,   32'h0, rd);
    run("st_f3_4",      1'b1, 3'd4, 32'h10,   32'h0, rd);

    // Response back-pressure with a second request waiting
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = '0;
    @(posedge clk); #1;
    acc0 = acc_cnt;
    req_addr = 32'h20;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_resp_rdata", resp_rdata, 32'h8000FF7F);
      check("bp_req_ready",  {31'd0, req_ready},  32'd0);
      @(posedge clk); #1;
    end
    check("bp_no_accept", acc_cnt, acc0);
    resp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_released_ready", {31'd0, req_ready},  32'd1);
    check("bp_released_valid", {31'd0, resp_valid}, 32'd0);
    check("bp_accept_count",   acc_cnt, acc0);

    // Reset during the WRITE cycle of a byte store
    run("sw30", 1'b1, 3'd2, 32'h30, 32'hCAFEF00D, rd);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h31; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_op_read_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    check("rst_op_write_we", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_op_we_after",    {31'd0, mem_we},     32'd0);
    check("rst_op_ready_after", {31'd0, req_ready},  32'd1);
    for (int k = 0; k < 3; k++) begin
      check("rst_op_no_resp", {31'd0, resp_valid}, 32'd0);
      @(posedge clk); #1;
    end

    // Randomized traffic over a small initialized region
    for (int i = 0; i < 16; i++) run("init", 1'b1, 3'd2, 32'h100 + 32'(4*i), $urandom, rd);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(7, 0);
      if (sel == 0)      a = 32'h1000 + 32'($urandom_range(63, 0));
      else if (sel == 1) a = $urandom;
      else               a = 32'h100 + 32'($urandom_range(63, 0));
      run("rand", 1'($urandom), 3'($urandom), a, $urandom, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
